wb_regfile: RTL and testbench
=============================

# wb_regfile

Write-back stage and architectural register file of the MIPS pipeline. It consumes the MEM/WB latch outputs, selects the write-back value, and commits it to a 32-entry register file. It serves two combinational read ports to the decode stage, with same-cycle write bypass. On a halt it freezes the architectural state and streams all 32 registers out over a valid/ready debug port.

## Interface
- len_data, 32, data/register width
- num_bits, 5, register index width (32 registers)
- len_wb_bus, 2, write-back control bus width

Ports:
- clk  in  1  pipeline clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- read_data  in  len_data  load data from MEM/WB
- addr_mem  in  len_data  ALU result from MEM/WB
- writeBack_bus  in  len_wb_bus  bit0 RegWrite, bit1 MemtoReg
- write_reg  in  num_bits  destination register index
- halt_flag_wb  in  1  halt instruction has reached write-back
- rs_addr, rt_addr  in  num_bits each  decode-stage read indices
- rs_data, rt_data  out  len_data each  read data (combinational)
- wb_data  out  len_data  selected write-back value (for forwarding)
- halted  out  1  high in HALTED, DUMP, DONE
- write_count  out  len_data  number of committed register writes
- dump_req  in  1  start register dump (honoured only when halted)
- dump_valid  out  1  dump word present
- dump_ready  in  1  consumer accepts dump word
- dump_index  out  num_bits  index of current dump word
- dump_data  out  len_data  value of register dump_index
- dump_last  out  1  dump_valid and dump_index == 31
- dump_done  out  1  high in DONE

## Operation
- wb_data = MemtoReg ? read_data : addr_mem (combinational, always driven).
- Commit: in RUN, with RegWrite=1, halt_flag_wb=0 and write_reg != 0 → regs[write_reg] <= wb_data, and write_count increments by 1 (wraps modulo 2^len_data).
- A write to r0 is discarded and does not increment write_count. r0 always reads 0.
- Reads: rs_data = (rs_addr == 0) ? 0 : (commit_this_cycle && write_reg == rs_addr) ? wb_data : regs[rs_addr]. rt_data is the same with rt_addr.
- FSM states RUN, HALTED, DUMP, DONE:
  - RUN → HALTED when halt_flag_wb=1. Any write presented in that same cycle is suppressed.
  - HALTED → DUMP on dump_req=1; dump_index <= 0.
  - DUMP: dump_valid=1 and dump_data = regs[dump_index]. On valid&&ready, dump_index increments. A transfer at index 31 moves to DONE.
  - DONE → DUMP on dump_req=1 (restart from index 0). Otherwise stays in DONE.
  - Only reset returns the FSM to RUN.
- Outside RUN, no register writes occur, write_count is frozen, and the read bypass is inactive.
- dump_req is ignored in RUN and DUMP.
- dump_valid holds high, and dump_index and dump_data stay stable, until accepted.

## Timing
- Reset (sync, checked at the clk edge): all 32 registers cleared to 0, state RUN, write_count=0, dump_index=0. This gives halted=0, dump_valid=0, dump_last=0, dump_done=0.
- Reset asserted mid-dump aborts the dump and returns to RUN on the next edge.
- Write latency: a commit is visible in regs after the edge, and to readers in the same cycle through the bypass.
- halted rises the cycle after halt_flag_wb is sampled high.
- dump_valid rises the cycle after dump_req is sampled in HALTED or DONE.
- With dump_ready held at 1, the 32 words transfer in 32 consecutive cycles, and dump_done rises the following cycle.
- Backpressure of any length is allowed; there is no word loss or duplication.

## Test plan
- Reset: assert reset for 2 cycles with writes pending. Every rs/rt read returns 0, write_count=0, halted=0.
- Write/bypass: RegWrite=1, MemtoReg=0, addr_mem=0x1234, write_reg=5, rs_addr=5 in the same cycle. rs_data=0x1234 that cycle and after. Repeat with MemtoReg=1, read_data=0xDEADBEEF, write_reg=0: r0 stays 0 and write_count is unchanged.
- Halt suppression: write r7=0xAA while halt_flag_wb=1. r7 keeps its old value, halted=1 next cycle, and later writes to r7=0xBB are ignored.
- Dump with ready=1: preload rN=N*3, halt, pulse dump_req. dump_data sequence is 0,3,...,93 over 32 cycles, dump_last on index 31, then dump_done=1.
- Backpressure: same as the previous test, with dump_ready toggled 1,0,0,1 in a pattern. Each index appears exactly once and dump_data is stable while ready=0. Pulsing dump_req in DONE restarts at index 0.
- Reset mid-dump: assert reset at index 10. Next cycle state is RUN with dump_valid=0 and all registers 0.

Source files
------------

// File: rtl/wb_regfile.sv
// wb_regfile: MIPS write-back stage plus 32-entry architectural register file.
//   Selects the write-back value from the MEM/WB latch and commits it.
//   Two combinational read ports (rs/rt) bypass a same-cycle commit.
//   After a halt, the register state is frozen. All registers can then be
//   streamed out over a valid/ready dump port.
// Ports:
//   clk, reset           clock; synchronous active-high reset
//   read_data, addr_mem  load data / ALU result from MEM/WB
//   writeBack_bus        [0] RegWrite, [1] MemtoReg
//   write_reg            destination index
//   halt_flag_wb         halt reached write-back
//   rs/rt_addr/_data     decode read ports
//   wb_data              selected write-back value (forwarding)
//   halted, write_count  status
//   dump_*               register dump stream

module wb_regfile_cell #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (reset)   q <= '0;
    else if (we) q <= d;
  end
endmodule

module wb_regfile #(
  parameter int len_data   = 32,
  parameter int num_bits   = 5,
  parameter int len_wb_bus = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [len_data-1:0]   read_data,
  input  logic [len_data-1:0]   addr_mem,
  input  logic [len_wb_bus-1:0] writeBack_bus,
  input  logic [num_bits-1:0]   write_reg,
  input  logic                  halt_flag_wb,
  input  logic [num_bits-1:0]   rs_addr,
  input  logic [num_bits-1:0]   rt_addr,
  output logic [len_data-1:0]   rs_data,
  output logic [len_data-1:0]   rt_data,
  output logic [len_data-1:0]   wb_data,
  output logic                  halted,
  output logic [len_data-1:0]   write_count,
  input  logic                  dump_req,
  output logic                  dump_valid,
  input  logic                  dump_ready,
  output logic [num_bits-1:0]   dump_index,
  output logic [len_data-1:0]   dump_data,
  output logic                  dump_last,
  output logic                  dump_done
);
  localparam int NUM_REGS = 1 << num_bits;
  localparam logic [num_bits-1:0] IDX_ONE  = 1;
  localparam logic [num_bits-1:0] IDX_LAST = '1;
  localparam logic [len_data-1:0] CNT_ONE  = 1;

  typedef enum logic [1:0] {RUN, HALTED, DUMP, DONE} state_t;
  state_t state;

  logic [NUM_REGS-1:0][len_data-1:0] regs;
  logic reg_write, mem_to_reg, commit;

  assign reg_write  = writeBack_bus[0];
  assign mem_to_reg = writeBack_bus[1];
  assign wb_data    = mem_to_reg ? read_data : addr_mem;

  // A halt arriving in write-back kills its own-cycle write as well.
  assign commit = (state == RUN) && reg_write && !halt_flag_wb &&
                  (write_reg != '0);

  // r0 has no storage; it is hardwired to zero.
  assign regs[0] = '0;

  genvar g;
  generate
    for (g = 1; g < NUM_REGS; g++) begin : g_reg
      wb_regfile_cell #(.W(len_data)) u_cell (
        .clk   (clk),
        .reset (reset),
        .we    (commit && (write_reg == num_bits'(g))),
        .d     (wb_data),
        .q     (regs[g])
      );
    end
  endgenerate

  always_comb begin
    rs_data = regs[rs_addr];
    if (commit && write_reg == rs_addr) rs_data = wb_data;
    if (rs_addr == '0) rs_data = '0;
  end

  always_comb begin
    rt_data = regs[rt_addr];
    if (commit && write_reg == rt_addr) rt_data = wb_data;
    if (rt_addr == '0) rt_data = '0;
  end

  always_ff @(posedge clk) begin
    if (reset)       write_count <= '0;
    else if (commit) write_count <= write_count + CNT_ONE;
  end

  // Dump FSM; status outputs are registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RUN;
      halted     <= 1'b0;
      dump_valid <= 1'b0;
      dump_done  <= 1'b0;
      dump_index <= '0;
    end else begin
      case (state)
        RUN: begin
          if (halt_flag_wb) begin
            state  <= HALTED;
            halted <= 1'b1;
          end
        end
        HALTED, DONE: begin
          if (dump_req) begin
            state      <= DUMP;
            dump_valid <= 1'b1;
            dump_done  <= 1'b0;
            dump_index <= '0;
          end
        end
        DUMP: begin
          if (dump_ready) begin
            if (dump_index == IDX_LAST) begin
              state      <= DONE;
              dump_valid <= 1'b0;
              dump_done  <= 1'b1;
            end else begin
              dump_index <= dump_index + IDX_ONE;
            end
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  assign dump_data = regs[dump_index];
  assign dump_last = dump_valid && (dump_index == IDX_LAST);
endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] read_data, addr_mem;
  logic [1:0]  writeBack_bus;
  logic [4:0]  write_reg;
  logic        halt_flag_wb;
  logic [4:0]  rs_addr, rt_addr;
  logic [31:0] rs_data, rt_data, wb_data, write_count;
  logic        halted;
  logic        dump_req, dump_valid, dump_ready, dump_last, dump_done;
  logic [4:0]  dump_index;
  logic [31:0] dump_data;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk(clk), .reset(reset), .read_data(read_data), .addr_mem(addr_mem),
    .writeBack_bus(writeBack_bus), .write_reg(write_reg),
    .halt_flag_wb(halt_flag_wb), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data), .rt_data(rt_data), .wb_data(wb_data),
    .halted(halted), .write_count(write_count), .dump_req(dump_req),
    .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_index(dump_index), .dump_data(dump_data),
    .dump_last(dump_last), .dump_done(dump_done)
  );

  // Inputs change just after the falling edge; outputs are sampled 1ns later.
  task automatic idle();
    writeBack_bus = 2'b00; halt_flag_wb = 1'b0; dump_req = 1'b0;
    write_reg = '0; addr_mem = '0; read_data = '0;
  endtask

  task automatic do_reset();
    @(negedge clk); idle(); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  // Stimulus only: rN = N*3 for N = 1..31.
  task automatic preload();
    for (int n = 1; n < 32; n++) begin
      @(negedge clk);
      writeBack_bus = 2'b01; write_reg = 5'(n); addr_mem = 32'(n * 3);
    end
    @(negedge clk); idle();
  endtask

  task automatic halt_and_start();
    @(negedge clk); halt_flag_wb = 1'b1;
    @(negedge clk); halt_flag_wb = 1'b0; dump_req = 1'b1;
    @(negedge clk); dump_req = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; writeBack_bus = 2'b01; write_reg = 5'd3; addr_mem = 32'h55;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0; idle();
    #1;
    for (int i = 0; i < 32; i++) begin
      rs_addr = 5'(i); rt_addr = 5'(31 - i); #1;
      n_cmp++;
      if (rs_data !== 32'h0 || rt_data !== 32'h0) begin
        n_err++;
        $display("FAIL reset_read[%0d]: rs=%h rt=%h exp 0", i, rs_data, rt_data);
      end
    end
    n_cmp++;
    if (write_count !== 32'h0 || halted !== 1'b0 || dump_valid !== 1'b0 ||
        dump_done !== 1'b0 || dump_last !== 1'b0) begin
      n_err++;
      $display("FAIL reset_status: wc=%h halted=%b dv=%b dd=%b dl=%b exp 0",
               write_count, halted, dump_valid, dump_done, dump_last);
    end
  endtask

  task automatic test_write_bypass();
    @(negedge clk);
    writeBack_bus = 2'b01; addr_mem = 32'h1234; read_data = 32'hFFFF_0000;
    write_reg = 5'd5; rs_addr = 5'd5; rt_addr = 5'd6;
    #1;
    n_cmp++;
    if (wb_data !== 32'h1234 || rs_data !== 32'h1234 || rt_data !== 32'h0) begin
      n_err++;
      $display("FAIL bypass: wb=%h rs=%h rt=%h exp 1234/1234/0", wb_data, rs_data, rt_data);
    end
    @(negedge clk); idle(); #1;
    n_cmp++;
    if (rs_data !== 32'h1234 || write_count !== 32'd1) begin
      n_err++;
      $display("FAIL write_commit: rs=%h wc=%0d exp 1234/1", rs_data, write_count);
    end
    writeBack_bus = 2'b11; read_data = 32'hDEADBEEF; addr_mem = 32'h1;
    write_reg = 5'd0; rs_addr = 5'd0; rt_addr = 5'd5;
    #1;
    n_cmp++;
    if (wb_data !== 32'hDEADBEEF || rs_data !== 32'h0 || rt_data !== 32'h1234) begin
      n_err++;
      $display("FAIL r0_write: wb=%h rs=%h rt=%h exp deadbeef/0/1234", wb_data, rs_data, rt_data);
    end
    @(negedge clk); idle(); #1;
    n_cmp++;
    if (rs_data !== 32'h0 || write_count !== 32'd1) begin
      n_err++;
      $display("FAIL r0_discard: rs=%h wc=%0d exp 0/1", rs_data, write_count);
    end
  endtask

  task automatic test_halt();
    @(negedge clk);
    writeBack_bus = 2'b01; write_reg = 5'd7; addr_mem = 32'h11; rs_addr = 5'd7;
    @(negedge clk);
    addr_mem = 32'hAA; halt_flag_wb = 1'b1;
    #1;
    n_cmp++;
    if (rs_data !== 32'h11 || halted !== 1'b0 || write_count !== 32'd2) begin
      n_err++;
      $display("FAIL halt_suppress: rs=%h halted=%b wc=%0d exp 11/0/2", rs_data, halted, write_count);
    end
    @(negedge clk);
    halt_flag_wb = 1'b0; addr_mem = 32'hBB;
    #1;
    n_cmp++;
    if (halted !== 1'b1 || rs_data !== 32'h11) begin
      n_err++;
      $display("FAIL halted_rise: halted=%b rs=%h exp 1/11", halted, rs_data);
    end
    @(negedge clk); idle(); #1;
    n_cmp++;
    if (rs_data !== 32'h11 || write_count !== 32'd2 || dump_valid !== 1'b0) begin
      n_err++;
      $display("FAIL halt_frozen: rs=%h wc=%0d dv=%b exp 11/2/0", rs_data, write_count, dump_valid);
    end
  endtask

  task automatic test_dump_ready();
    do_reset();
    preload();
    #1;
    n_cmp++;
    if (write_count !== 32'd31) begin
      n_err++;
      $display("FAIL preload_count: wc=%0d exp 31", write_count);
    end
    dump_ready = 1'b1;
    halt_and_start();
    for (int i = 0; i < 32; i++) begin
      #1;
      n_cmp++;
      if (dump_valid !== 1'b1 || dump_index !== 5'(i) || dump_data !== 32'(i * 3) ||
          dump_last !== (i == 31) || dump_done !== 1'b0) begin
        n_err++;
        $display("FAIL dump_word[%0d]: v=%b idx=%0d data=%0d last=%b exp 1/%0d/%0d/%b",
                 i, dump_valid, dump_index, dump_data, dump_last, i, i * 3, i == 31);
      end
      @(negedge clk);
    end
    #1;
    n_cmp++;
    if (dump_done !== 1'b1 || dump_valid !== 1'b0 || halted !== 1'b1) begin
      n_err++;
      $display("FAIL dump_done: done=%b v=%b halted=%b exp 1/0/1", dump_done, dump_valid, halted);
    end
  endtask

  task automatic test_backpressure();
    logic [3:0]  pat;
    int          exp_idx, cyc;
    logic        prev_ready;
    logic [31:0] prev_data;
    pat = 4'b1001;
    do_reset();
    preload();
    dump_ready = 1'b0;
    halt_and_start();
    exp_idx = 0; cyc = 0; prev_ready = 1'b1; prev_data = '0;
    while (exp_idx < 32 && cyc < 200) begin
      dump_ready = pat[cyc % 4];
      #1;
      n_cmp++;
      if (dump_valid !== 1'b1 || dump_index !== 5'(exp_idx) ||
          dump_data !== 32'(exp_idx * 3) ||
          (!prev_ready && dump_data !== prev_data)) begin
        n_err++;
        $display("FAIL bp_word[c%0d]: v=%b idx=%0d data=%0d exp 1/%0d/%0d",
                 cyc, dump_valid, dump_index, dump_data, exp_idx, exp_idx * 3);
      end
      prev_ready = dump_ready; prev_data = dump_data;
      if (dump_ready) exp_idx++;
      cyc++;
      @(negedge clk);
    end
    n_cmp++;
    if (exp_idx != 32) begin
      n_err++;
      $display("FAIL bp_timeout: transferred=%0d exp 32", exp_idx);
    end
    #1;
    n_cmp++;
    if (dump_done !== 1'b1 || dump_valid !== 1'b0) begin
      n_err++;
      $display("FAIL bp_done: done=%b v=%b exp 1/0", dump_done, dump_valid);
    end
    dump_ready = 1'b0;
    dump_req = 1'b1;
    @(negedge clk); dump_req = 1'b0; #1;
    n_cmp++;
    if (dump_valid !== 1'b1 || dump_index !== 5'd0 || dump_done !== 1'b0 ||
        dump_data !== 32'h0) begin
      n_err++;
      $display("FAIL restart: v=%b idx=%0d done=%b data=%h exp 1/0/0/0",
               dump_valid, dump_index, dump_done, dump_data);
    end
  endtask

  task automatic test_reset_mid_dump();
    int cyc;
    cyc = 0;
    dump_ready = 1'b1;
    while (dump_index !== 5'd10 && cyc < 40) begin
      @(negedge clk); #1; cyc++;
    end
    n_cmp++;
    if (dump_index !== 5'd10 || dump_data !== 32'd30) begin
      n_err++;
      $display("FAIL mid_reach: idx=%0d data=%0d exp 10/30", dump_index, dump_data);
    end
    reset = 1'b1;
    @(negedge clk); reset = 1'b0; dump_ready = 1'b0; #1;
    n_cmp++;
    if (dump_valid !== 1'b0 || halted !== 1'b0 || dump_index !== 5'd0 ||
        dump_done !== 1'b0 || write_count !== 32'h0) begin
      n_err++;
      $display("FAIL mid_reset_status: v=%b halted=%b idx=%0d done=%b wc=%0d exp 0",
               dump_valid, halted, dump_index, dump_done, write_count);
    end
    for (int i = 1; i < 32; i++) begin
      rs_addr = 5'(i); #1;
      n_cmp++;
      if (rs_data !== 32'h0) begin
        n_err++;
        $display("FAIL mid_reset_reg[%0d]: got %h exp 0", i, rs_data);
      end
    end
  endtask

  initial begin
    reset = 1'b0; dump_ready = 1'b0; rs_addr = '0; rt_addr = '0;
    idle();
    test_reset();
    test_write_bypass();
    test_halt();
    test_dump_ready();
    test_backpressure();
    test_reset_mid_dump();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
